// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmit byte queue feeding the transceiver one byte per tx_done
// Optional watermark interrupt (wm_level/wm_irq) enabled by defining UART_TX_FIFO_WATERMARK_EN
module uart_tx_fifo #(
    parameter int depth_log2 = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [7:0]          wr_data,
    input  logic                wr_en,
    input  logic                ovf_clr,
    output logic [7:0]          tx_data,
    output logic                tx_wr,
    input  logic                tx_done,
    output logic [depth_log2:0] level,
    output logic                full,
    output logic                empty,
    output logic                busy,
    output logic                overflow,
`ifdef UART_TX_FIFO_WATERMARK_EN
    input  logic [depth_log2:0] wm_level,
    output logic                wm_irq,
`endif
    output logic                drain_irq
);

    localparam int DEPTH = 1 << depth_log2;
    localparam logic [depth_log2:0] FULL_LEVEL = {1'b1, {depth_log2{1'b0}}};
    localparam logic [depth_log2:0] LEVEL_ONE  = {{depth_log2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_ptr;
    logic [depth_log2:0]   level_next;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // full is judged before any same-cycle pop, so a write into a full queue is always dropped
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign busy  = (state != ST_IDLE);
    assign push  = wr_en && !full;
    assign drop  = wr_en && full;
    assign pop   = (state == ST_IDLE) && !empty;

    always_comb begin
        level_next = level;
        if (push && !pop)
            level_next = level + LEVEL_ONE;
        else if (pop && !push)
            level_next = level - LEVEL_ONE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            tx_data   <= 8'h00;
            tx_wr     <= 1'b0;
            overflow  <= 1'b0;
            drain_irq <= 1'b0;
        end else begin
            tx_wr     <= 1'b0;
            drain_irq <= 1'b0;
            level     <= level_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_wr   <= 1'b1;
                        rd_ptr  <= rd_ptr + 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: state <= ST_WAIT;
                ST_WAIT: begin
                    if (tx_done) begin
                        state <= ST_IDLE;
                        // a byte pushed in the completion cycle means the queue is not drained
                        if (empty && !push)
                            drain_irq <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_WATERMARK_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            wm_irq <= 1'b0;
        else
            wm_irq <= pop && !push && (level > wm_level) && (level_next <= wm_level);
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized bench for uart_tx_fifo against a queue-based reference model
module tb_uart_tx_fifo;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic           sys_clk   = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic [7:0]     wr_data   = 8'h00;
    logic           wr_en     = 1'b0;
    logic           ovf_clr   = 1'b0;
    logic           tx_done   = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_wr;
    logic [DL2:0]   level;
    logic           full;
    logic           empty;
    logic           busy;
    logic           overflow;
    logic           drain_irq;
`ifdef UART_TX_FIFO_WATERMARK_EN
    logic [DL2:0]   wm_level = '0;
    logic           wm_irq;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] m_q[$];
    bit         m_busy   = 0;
    int         m_age    = 0;
    bit         m_ovf    = 0;
    bit         m_drain  = 0;
    bit         m_txwr   = 0;
    logic [7:0] m_txdata = 8'h00;
    int         sent     = 0;
    bit         auto_done  = 0;
    int         done_delay = 1;

    uart_tx_fifo #(.depth_log2(DL2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .ovf_clr   (ovf_clr),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_done   (tx_done),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .overflow  (overflow),
`ifdef UART_TX_FIFO_WATERMARK_EN
        .wm_level  (wm_level),
        .wm_irq    (wm_irq),
`endif
        .drain_irq (drain_irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: the model consumes the inputs seen at the edge, then every output is compared
    task automatic step();
        int  n_pre;
        bit  accept;
        bit  dropped;
        if (auto_done)
            tx_done = m_busy && (m_age >= done_delay);
        @(posedge sys_clk);
        if (!sys_rst_n) begin
            m_q.delete();
            m_busy   = 0;
            m_age    = 0;
            m_ovf    = 0;
            m_drain  = 0;
            m_txwr   = 0;
            m_txdata = 8'h00;
        end else begin
            n_pre   = m_q.size();
            accept  = wr_en && (n_pre < DEPTH);
            dropped = wr_en && (n_pre == DEPTH);
            m_txwr  = 0;
            m_drain = 0;
            if (m_busy) begin
                if (m_age == 0)
                    m_age = 1;
                else if (tx_done) begin
                    m_busy  = 0;
                    m_drain = (n_pre == 0) && !accept;
                end else
                    m_age++;
            end else if (n_pre > 0) begin
                m_txdata = m_q.pop_front();
                m_txwr   = 1;
                m_busy   = 1;
                m_age    = 0;
                sent++;
            end
            if (accept)
                m_q.push_back(wr_data);
            if (dropped)
                m_ovf = 1;
            else if (ovf_clr)
                m_ovf = 0;
        end
        #1;
        check("level",     level,     m_q.size());
        check("empty",     empty,     m_q.size() == 0);
        check("full",      full,      m_q.size() == DEPTH);
        check("busy",      busy,      m_busy);
        check("overflow",  overflow,  m_ovf);
        check("drain_irq", drain_irq, m_drain);
        check("tx_wr",     tx_wr,     m_txwr);
        check("tx_data",   tx_data,   m_txdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held with a write pending
        #1;
        sys_rst_n = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'h3C;
        step();
        step();
        check("rst_level",   level,    0);
        check("rst_empty",   empty,    1);
        check("rst_tx_wr",   tx_wr,    0);
        check("rst_ovf",     overflow, 0);
        check("rst_tx_data", tx_data,  8'h00);
        sys_rst_n = 1'b1;
        wr_en     = 1'b0;
        step();

        // single byte with a slow transceiver
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        step();
        check("single_tx_wr",   tx_wr,   1);
        check("single_tx_data", tx_data, 8'hA5);
        repeat (19) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("single_drain", drain_irq, 1);
        check("single_busy",  busy,      0);
        step();

        // burst 00..0F with automatic completions
        auto_done  = 1;
        done_delay = 3;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 500 && (m_busy || m_q.size() != 0); c++)
            step();
        check("burst_drained", (m_busy || m_q.size() != 0), 0);
        check("burst_no_ovf",  overflow, 0);
        auto_done = 0;
        tx_done   = 1'b0;
        step();

        // overflow: 17 writes fill the queue behind the in-flight byte, the 18th is dropped
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            step();
        end
        check("ovf_level16", level, 16);
        check("ovf_full",    full,  1);
        wr_data = 8'hEE;
        step();
        check("ovf_set", overflow, 1);
        wr_en   = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // write in the IDLE pop cycle of a full queue is dropped
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        check("full_pop_level", level,    15);
        check("full_pop_ovf",   overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        check("push_pop_level", level, 15);

        // random traffic, pointers wrap several times
        auto_done = 1;
        for (int c = 0; c < 4000 && sent < 80; c++) begin
            wr_en      = ($urandom_range(0, 2) != 0);
            wr_data    = 8'($urandom);
            ovf_clr    = ($urandom_range(0, 7) == 0);
            done_delay = $urandom_range(1, 4);
            step();
        end
        check("rand_sent", sent >= 80, 1);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        for (int c = 0; c < 1000 && (m_busy || m_q.size() != 0); c++)
            step();
        check("rand_drained", (m_busy || m_q.size() != 0), 0);
        auto_done = 0;
        tx_done   = 1'b0;
        step();

        // reset during WAIT with five bytes queued
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        step();
        step();
        check("mid_level", level, 5);
        check("mid_busy",  busy,  1);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        tx_done   = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (4) step();
        check("post_rst_level", level,     0);
        check("post_rst_tx_wr", tx_wr,     0);
        check("post_rst_drain", drain_irq, 0);
        check("post_rst_busy",  busy,      0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
